csr_trap_unit: RTL
==================

Name: csr_trap_unit

Overview:
Machine-mode CSR file and trap controller for the RV32I core. It generalises the existing CSR block in four ways:
- parametrised fast-interrupt count;
- priority-encoded mcause with trap entry, mret return and vectored mtvec;
- mcycle/minstret counters with mcountinhibit;
- illegal-access flag.

It sits beside the decode/execute stage. It is the only place mstatus/mepc/mcause/mtval are updated.

Parameters:
NUM_FAST_IRQ, 16, number of platform fast interrupts (0..16); mip/mie bits [16+NUM_FAST_IRQ-1:16] are implemented.
COUNTER_WIDTH, 64, width of mcycle/minstret (33..64); upper unimplemented bits read 0.
MTVEC_RESET, 32'h00000000, reset value of mtvec.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
csr_write_enable  in  1  CSR instruction executes this cycle
func3  in  3  CSR op: 001 RW, 010 RS, 011 RC; bit2=1 selects the immediate source
csr_immediate  in  5  zimm, zero-extended
csr_address  in  12  CSR address
csr_data_in  in  32  rs1 value
csr_data_out  out  32  combinational read data (old value)
csr_illegal  out  1  combinational; write_enable to an unimplemented or read-only address
irq_external/irq_timer/irq_software  in  1  level interrupt requests
irq_fast  in  NUM_FAST_IRQ  level fast interrupt requests
instr_retired  in  1  one instruction retired this cycle
boundary_valid  in  1  core is at an instruction boundary; interrupts may be taken
boundary_pc  in  32  PC of the next instruction to execute
exception_valid  in  1  synchronous exception
exception_code  in  5  exception cause
exception_pc  in  32  faulting PC
exception_tval  in  32  mtval value
mret  in  1  mret executes
trap_taken  out  1  registered one-cycle pulse; redirect fetch
trap_target  out  32  registered; valid while trap_taken is high
mepc_out  out  32  current mepc; mret target

Behaviour:
- Reset values:
  - all outputs 0
  - mstatus.MIE=0, MPIE=1
  - mie=0, mip=0, mepc=0, mcause=0, mtval=0, mscratch=0
  - mtvec=MTVEC_RESET
  - counters=0, mcountinhibit=0
- mip is registered from the irq inputs with 1-cycle latency. mip is read-only; writes are ignored and csr_illegal is not flagged for them.
- Write data: RW=src, RS=old|src, RC=old&~src, where src is zimm when func3[2]=1 and csr_data_in otherwise. The write is always performed.
- Register masks:
  - mtvec bit1 forced 0
  - mepc[1:0] forced 0
  - mie writable bits are 3, 7, 11 and the implemented fast bits only
- Counter CSRs:
  - mcycle B00/B80 and minstret B02/B82 are read/write.
  - C00/C80/C02/C82 are read-only shadows.
  - mcountinhibit 0x320 implements bits 0 (CY) and 2 (IR) only.
  - mcycle increments every cycle unless CY=1. minstret increments on instr_retired unless IR=1.
  - A CSR write to a counter half replaces the increment in that cycle. The other half holds.
  - Counters wrap at 2^COUNTER_WIDTH to 0.
- Read-only IDs: marchid=0x18, mimpid=0x07, misa=0x40000100, mstatush=0. Unimplemented addresses read 0.
- Interrupt request: int_req = boundary_valid & mstatus.MIE & |(mie & mip).
- Cause priority: external(11) > software(3) > timer(7) > fast (16+i, lowest i wins).
- Event priority within a cycle: reset > exception > interrupt > mret > CSR write. A lower-priority event in the same cycle is dropped entirely, including its CSR write.
- Exception entry, at the clock edge:
  - mepc=exception_pc, mcause={0,code}, mtval=exception_tval
  - MPIE=MIE, MIE=0
  - next cycle: trap_taken=1, trap_target=mtvec base (direct mode regardless of mtvec mode)
- Interrupt entry:
  - mepc=boundary_pc, mcause={1,code}, mtval=0
  - MPIE=MIE, MIE=0
  - trap_target = base+4*code when mtvec[1:0]=01, else base
- mret: MIE=MPIE, MPIE=1. No trap_taken; the core jumps to mepc_out.
- Because MIE=0 after entry, back-to-back traps cannot occur from interrupts. An exception during trap_taken is still accepted.
- Reset asserted mid-entry clears trap_taken on the next edge.

Decomposition:
- csr_pkg holds:
  - CSR address localparams
  - cause-code constants
  - mcountinhibit bit indices
  - func3 op encodings
- One sub-module, csr_irq_prio: combinational priority encoder from (mie&mip) to {valid, code[4:0]}, parametrised by NUM_FAST_IRQ.
- The rest lives in csr_trap_unit.

Test Plan:
1. Write mtvec=0x00001001 (vectored), mie=0x800, mstatus=0x8; pulse irq_external with boundary_valid=1 and boundary_pc=0x200 -> after 1-cycle mip latency and one more edge: trap_taken=1, trap_target=0x102C, mepc=0x200, mcause=0x8000000B, mstatus reads 0x1880.
2. Enable all interrupts; raise timer, software and irq_fast[2] together -> mcause=0x80000003; mret -> MIE=1, MPIE=1; software cleared -> next trap mcause=0x80000007.
3. exception_valid (code 2, pc 0x40, tval 0xDEAD) in the same cycle as a pending interrupt and a csr write to mscratch -> mcause=2, mtval=0xDEAD, target=base, mscratch unchanged.
4. Write mcycle low=0xFFFFFFFF, high=0 -> two cycles later mcycleh=1; set mcountinhibit=0x5 -> mcycle and minstret hold while instr_retired pulses.
5. csrrs with zimm=0x8 to mstatus, then csrrc zimm=0x8 -> MIE toggles 1 then 0; write to 0xF12 -> csr_illegal=1, value unchanged.
6. NUM_FAST_IRQ=4: write mie=0xFFFFFFFF -> reads 0x000F0888; reset mid-trap -> trap_taken=0, mepc=0.

Source files
------------

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared constants for the machine-mode CSR file and trap unit
//
// Purpose: CSR address map, cause codes, mcountinhibit bit indices, CSR op
// encodings and the fast-interrupt mask helper used by csr_trap_unit and
// csr_irq_prio.
package csr_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MSTATUSH      = 12'h310;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;

  // Fixed read-only values
  localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;
  localparam logic [31:0] MARCHID_VALUE = 32'h0000_0018;
  localparam logic [31:0] MIMPID_VALUE  = 32'h0000_0007;

  // Interrupt cause codes (also the mip/mie bit positions)
  localparam logic [4:0] CAUSE_M_SOFTWARE = 5'd3;
  localparam logic [4:0] CAUSE_M_TIMER    = 5'd7;
  localparam logic [4:0] CAUSE_M_EXTERNAL = 5'd11;
  localparam int         FAST_IRQ_BASE    = 16;

  // mcountinhibit bit indices
  localparam int CNT_CY = 0;
  localparam int CNT_IR = 2;
  localparam logic [31:0] MCOUNTINHIBIT_MASK = 32'h0000_0005;

  // Standard writable mie bits (MSIE, MTIE, MEIE)
  localparam logic [31:0] MIE_STD_MASK = 32'h0000_0888;

  // func3[1:0] of a CSR instruction; func3[2] selects the zimm source
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  localparam int F3_IMM_BIT = 2;

  // Mask of the implemented fast-interrupt bits in mie/mip
  function automatic logic [31:0] fast_irq_mask(input int n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) m[FAST_IRQ_BASE + i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/csr_irq_prio.sv
// rtl/csr_irq_prio.sv - combinational interrupt cause priority encoder
//
// Purpose: picks the highest-priority enabled-and-pending interrupt.
// Order: external(11) > software(3) > timer(7) > fast (16+i, lowest i wins).
// Ports:
//   ext_pend, sw_pend, tmr_pend  in   standard interrupts, already ANDed with mie
//   fast_pend                    in   fast interrupts, already ANDed with mie
//   valid                        out  any interrupt pending
//   code                         out  cause code of the winner
module csr_irq_prio
  import csr_pkg::*;
#(
  parameter int NUM_FAST_IRQ = 16
) (
  input  logic                                           ext_pend,
  input  logic                                           sw_pend,
  input  logic                                           tmr_pend,
  input  logic [((NUM_FAST_IRQ > 0) ? NUM_FAST_IRQ : 1)-1:0] fast_pend,
  output logic                                           valid,
  output logic [4:0]                                     code
);

  // Later assignments override earlier ones, so the loop walks from the
  // lowest-priority source to the highest.
  always_comb begin
    valid = 1'b0;
    code  = 5'd0;
    for (int i = NUM_FAST_IRQ - 1; i >= 0; i--) begin
      if (fast_pend[i]) begin
        valid = 1'b1;
        code  = 5'(FAST_IRQ_BASE + i);
      end
    end
    if (tmr_pend) begin
      valid = 1'b1;
      code  = CAUSE_M_TIMER;
    end
    if (sw_pend) begin
      valid = 1'b1;
      code  = CAUSE_M_SOFTWARE;
    end
    if (ext_pend) begin
      valid = 1'b1;
      code  = CAUSE_M_EXTERNAL;
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode CSR file and trap controller
//
// Purpose: holds mstatus/mie/mip/mtvec/mscratch/mepc/mcause/mtval, the
// mcycle/minstret counters with mcountinhibit, and sequences trap entry and
// mret. Event priority in one cycle: reset > exception > interrupt > mret >
// CSR write; a losing event is dropped entirely.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   csr_write_enable, func3         CSR instruction strobe and op
//   csr_immediate, csr_data_in      zimm / rs1 write sources
//   csr_address                     CSR address
//   csr_data_out                    combinational old value of the CSR
//   csr_illegal                     write to unimplemented/read-only CSR
//   irq_external/timer/software     level interrupt requests
//   irq_fast                        level fast interrupt requests
//   instr_retired                   minstret increment strobe
//   boundary_valid, boundary_pc     interrupt window and resume PC
//   exception_valid/code/pc/tval    synchronous exception
//   mret                            return from trap
//   trap_taken, trap_target         registered redirect pulse and target
//   mepc_out                        current mepc (mret target)
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int          NUM_FAST_IRQ  = 16,
  parameter int          COUNTER_WIDTH = 64,
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           csr_write_enable,
  input  logic [2:0]                                     func3,
  input  logic [4:0]                                     csr_immediate,
  input  logic [11:0]                                    csr_address,
  input  logic [31:0]                                    csr_data_in,
  output logic [31:0]                                    csr_data_out,
  output logic                                           csr_illegal,
  input  logic                                           irq_external,
  input  logic                                           irq_timer,
  input  logic                                           irq_software,
  input  logic [((NUM_FAST_IRQ > 0) ? NUM_FAST_IRQ : 1)-1:0] irq_fast,
  input  logic                                           instr_retired,
  input  logic                                           boundary_valid,
  input  logic [31:0]                                    boundary_pc,
  input  logic                                           exception_valid,
  input  logic [4:0]                                     exception_code,
  input  logic [31:0]                                    exception_pc,
  input  logic [31:0]                                    exception_tval,
  input  logic                                           mret,
  output logic                                           trap_taken,
  output logic [31:0]                                    trap_target,
  output logic [31:0]                                    mepc_out
);

  localparam int          FAST_W   = (NUM_FAST_IRQ > 0) ? NUM_FAST_IRQ : 1;
  localparam logic [31:0] MIE_MASK = MIE_STD_MASK | fast_irq_mask(NUM_FAST_IRQ);

  logic                     mstatus_mie;
  logic                     mstatus_mpie;
  logic [31:0]              mie_q;
  logic [31:0]              mip_q;
  logic [31:0]              mip_d;
  logic [31:0]              mtvec_q;
  logic [31:0]              mscratch_q;
  logic [31:0]              mepc_q;
  logic [31:0]              mcause_q;
  logic [31:0]              mtval_q;
  logic [31:0]              mcountinhibit_q;
  logic [COUNTER_WIDTH-1:0] mcycle_q;
  logic [COUNTER_WIDTH-1:0] minstret_q;

  logic [63:0]              cyc_ext;
  logic [63:0]              ins_ext;
  logic [63:0]              cnt_tmp;
  logic [COUNTER_WIDTH-1:0] cyc_wr_lo;
  logic [COUNTER_WIDTH-1:0] cyc_wr_hi;
  logic [COUNTER_WIDTH-1:0] ins_wr_lo;
  logic [COUNTER_WIDTH-1:0] ins_wr_hi;

  logic [FAST_W-1:0]        fast_pend;
  logic                     irq_valid;
  logic [4:0]               irq_code;
  logic                     int_req;

  logic [31:0]              csr_rdata;
  logic                     write_accepted;
  logic [31:0]              src;
  logic [31:0]              wdata;
  csr_op_e                  op;

  logic                     take_exc;
  logic                     take_irq;
  logic                     take_mret;
  logic                     do_write;

  logic [31:0]              mtvec_base;
  logic [31:0]              irq_target;

  // Interrupt lines are sampled into mip one cycle before they can trap
  always_comb begin
    mip_d = '0;
    mip_d[CAUSE_M_EXTERNAL] = irq_external;
    mip_d[CAUSE_M_TIMER]    = irq_timer;
    mip_d[CAUSE_M_SOFTWARE] = irq_software;
    for (int i = 0; i < NUM_FAST_IRQ; i++) begin
      mip_d[FAST_IRQ_BASE + i] = irq_fast[i];
    end
  end

  always_comb begin
    fast_pend = '0;
    for (int i = 0; i < NUM_FAST_IRQ; i++) begin
      fast_pend[i] = mie_q[FAST_IRQ_BASE + i] & mip_q[FAST_IRQ_BASE + i];
    end
  end

  csr_irq_prio #(
    .NUM_FAST_IRQ(NUM_FAST_IRQ)
  ) u_irq_prio (
    .ext_pend  (mie_q[CAUSE_M_EXTERNAL] & mip_q[CAUSE_M_EXTERNAL]),
    .sw_pend   (mie_q[CAUSE_M_SOFTWARE] & mip_q[CAUSE_M_SOFTWARE]),
    .tmr_pend  (mie_q[CAUSE_M_TIMER] & mip_q[CAUSE_M_TIMER]),
    .fast_pend (fast_pend),
    .valid     (irq_valid),
    .code      (irq_code)
  );

  assign int_req = boundary_valid & mstatus_mie & irq_valid;

  // Counters are widened to 64 bits so both halves can be read and partially
  // replaced independently of COUNTER_WIDTH.
  always_comb begin
    cyc_ext = '0;
    ins_ext = '0;
    cyc_ext[COUNTER_WIDTH-1:0] = mcycle_q;
    ins_ext[COUNTER_WIDTH-1:0] = minstret_q;
    cnt_tmp = cyc_ext;
    cnt_tmp[31:0] = wdata;
    cyc_wr_lo = cnt_tmp[COUNTER_WIDTH-1:0];
    cnt_tmp = cyc_ext;
    cnt_tmp[63:32] = wdata;
    cyc_wr_hi = cnt_tmp[COUNTER_WIDTH-1:0];
    cnt_tmp = ins_ext;
    cnt_tmp[31:0] = wdata;
    ins_wr_lo = cnt_tmp[COUNTER_WIDTH-1:0];
    cnt_tmp = ins_ext;
    cnt_tmp[63:32] = wdata;
    ins_wr_hi = cnt_tmp[COUNTER_WIDTH-1:0];
  end

  // Read mux; write_accepted marks addresses a CSR write may target without
  // being illegal (mip is accepted but the write is discarded).
  always_comb begin
    csr_rdata      = '0;
    write_accepted = 1'b0;
    case (csr_address)
      CSR_MSTATUS: begin
        csr_rdata[12:11] = 2'b11;
        csr_rdata[7]     = mstatus_mpie;
        csr_rdata[3]     = mstatus_mie;
        write_accepted   = 1'b1;
      end
      CSR_MISA:          csr_rdata = MISA_VALUE;
      CSR_MSTATUSH:      csr_rdata = '0;
      CSR_MARCHID:       csr_rdata = MARCHID_VALUE;
      CSR_MIMPID:        csr_rdata = MIMPID_VALUE;
      CSR_MIE:           begin csr_rdata = mie_q;           write_accepted = 1'b1; end
      CSR_MTVEC:         begin csr_rdata = mtvec_q;         write_accepted = 1'b1; end
      CSR_MCOUNTINHIBIT: begin csr_rdata = mcountinhibit_q; write_accepted = 1'b1; end
      CSR_MSCRATCH:      begin csr_rdata = mscratch_q;      write_accepted = 1'b1; end
      CSR_MEPC:          begin csr_rdata = mepc_q;          write_accepted = 1'b1; end
      CSR_MCAUSE:        begin csr_rdata = mcause_q;        write_accepted = 1'b1; end
      CSR_MTVAL:         begin csr_rdata = mtval_q;         write_accepted = 1'b1; end
      CSR_MIP:           begin csr_rdata = mip_q;           write_accepted = 1'b1; end
      CSR_MCYCLE:        begin csr_rdata = cyc_ext[31:0];   write_accepted = 1'b1; end
      CSR_MCYCLEH:       begin csr_rdata = cyc_ext[63:32];  write_accepted = 1'b1; end
      CSR_MINSTRET:      begin csr_rdata = ins_ext[31:0];   write_accepted = 1'b1; end
      CSR_MINSTRETH:     begin csr_rdata = ins_ext[63:32];  write_accepted = 1'b1; end
      CSR_CYCLE:         csr_rdata = cyc_ext[31:0];
      CSR_CYCLEH:        csr_rdata = cyc_ext[63:32];
      CSR_INSTRET:       csr_rdata = ins_ext[31:0];
      CSR_INSTRETH:      csr_rdata = ins_ext[63:32];
      default:           csr_rdata = '0;
    endcase
  end

  assign csr_data_out = csr_rdata;
  assign csr_illegal  = csr_write_enable & ~write_accepted;

  assign src = func3[F3_IMM_BIT] ? {27'b0, csr_immediate} : csr_data_in;
  assign op  = csr_op_e'(func3[1:0]);

  always_comb begin
    case (op)
      OP_RW:   wdata = src;
      OP_RS:   wdata = csr_rdata | src;
      OP_RC:   wdata = csr_rdata & ~src;
      default: wdata = csr_rdata;
    endcase
  end

  assign take_exc  = exception_valid;
  assign take_irq  = ~exception_valid & int_req;
  assign take_mret = ~exception_valid & ~int_req & mret;
  assign do_write  = ~exception_valid & ~int_req & ~mret & csr_write_enable
                   & write_accepted & (op != OP_NONE);

  assign mtvec_base = {mtvec_q[31:2], 2'b00};
  assign irq_target = (mtvec_q[1:0] == 2'b01)
                    ? mtvec_base + {25'b0, irq_code, 2'b00}
                    : mtvec_base;

  assign mepc_out = mepc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie     <= 1'b0;
      mstatus_mpie    <= 1'b1;
      mie_q           <= '0;
      mip_q           <= '0;
      mtvec_q         <= MTVEC_RESET & ~32'h2;
      mscratch_q      <= '0;
      mepc_q          <= '0;
      mcause_q        <= '0;
      mtval_q         <= '0;
      mcountinhibit_q <= '0;
      mcycle_q        <= '0;
      minstret_q      <= '0;
      trap_taken      <= 1'b0;
      trap_target     <= '0;
    end else begin
      mip_q       <= mip_d;
      trap_taken  <= 1'b0;
      trap_target <= '0;

      if (!mcountinhibit_q[CNT_CY]) mcycle_q <= mcycle_q + COUNTER_WIDTH'(1);
      if (instr_retired && !mcountinhibit_q[CNT_IR]) minstret_q <= minstret_q + COUNTER_WIDTH'(1);

      if (take_exc) begin
        mepc_q       <= exception_pc;
        mcause_q     <= {27'b0, exception_code};
        mtval_q      <= exception_tval;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
        trap_taken   <= 1'b1;
        trap_target  <= mtvec_base;
      end else if (take_irq) begin
        mepc_q       <= boundary_pc;
        mcause_q     <= {1'b1, 26'b0, irq_code};
        mtval_q      <= '0;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
        trap_taken   <= 1'b1;
        trap_target  <= irq_target;
      end else if (take_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (do_write) begin
        case (csr_address)
          CSR_MSTATUS: begin
            mstatus_mie  <= wdata[3];
            mstatus_mpie <= wdata[7];
          end
          CSR_MIE:           mie_q           <= wdata & MIE_MASK;
          CSR_MTVEC:         mtvec_q         <= wdata & ~32'h2;
          CSR_MCOUNTINHIBIT: mcountinhibit_q <= wdata & MCOUNTINHIBIT_MASK;
          CSR_MSCRATCH:      mscratch_q      <= wdata;
          CSR_MEPC:          mepc_q          <= wdata & ~32'h3;
          CSR_MCAUSE:        mcause_q        <= wdata;
          CSR_MTVAL:         mtval_q         <= wdata;
          // A counter write overrides this cycle's increment of that counter
          CSR_MCYCLE:        mcycle_q        <= cyc_wr_lo;
          CSR_MCYCLEH:       mcycle_q        <= cyc_wr_hi;
          CSR_MINSTRET:      minstret_q      <= ins_wr_lo;
          CSR_MINSTRETH:     minstret_q      <= ins_wr_hi;
          default: ;
        endcase
      end
    end
  end

endmodule
